// File: rtl/issue_scheduler_pkg.sv
// Shared unit-type encodings and the buffered instruction entry for the issue scheduler.
package issue_pkg;
    localparam int NUM_UNITS     = 7;
    localparam int ISS_PAYLOAD_W = 32;

    localparam logic [2:0] TYPE_ALU    = 3'd0;
    localparam logic [2:0] TYPE_BR     = 3'd1;
    localparam logic [2:0] TYPE_DIV    = 3'd2;
    localparam logic [2:0] TYPE_PRIV   = 3'd3;
    localparam logic [2:0] TYPE_MUL    = 3'd4;
    localparam logic [2:0] TYPE_DCACHE = 3'd5;
    localparam logic [2:0] TYPE_LLSC   = 3'd6;

    typedef struct packed {
        logic [2:0]               utype;
        logic [4:0]               rj;
        logic                     rj_use;
        logic [4:0]               rk;
        logic                     rk_use;
        logic [4:0]               rd;
        logic                     rd_we;
        logic [ISS_PAYLOAD_W-1:0] payload;
    } iss_entry_t;

    function automatic logic [31:0] onehot32(input logic [4:0] idx);
        return 32'd1 << idx;
    endfunction
endpackage

// File: rtl/issue_scheduler_fifo.sv
// Synchronous FIFO of decoded entries; flush and reset both empty it in one cycle.
module issue_fifo
    import issue_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_push,
    input  iss_entry_t    i_data,
    input  logic          i_pop,
    output iss_entry_t    o_head,
    output logic          o_empty,
    output logic          o_full,
    output logic [CW-1:0] o_count
);
    iss_entry_t    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst && !i_flush) r_mem[r_wptr] <= i_data;
    end
endmodule

// File: rtl/issue_scheduler.sv
// In-order issue controller: FIFO head issues when its registers are free and its unit is ready.
// Optional ISSUE_SCHED_PERF_EN adds saturating RAW-stall and unit-stall counters.
module issue_scheduler
    import issue_pkg::*;
#(
    parameter int  DEPTH     = 4,
    parameter int  PAYLOAD_W = ISS_PAYLOAD_W,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_type,
    input  logic [4:0]           in_rj,
    input  logic                 in_rj_use,
    input  logic [4:0]           in_rk,
    input  logic                 in_rk_use,
    input  logic [4:0]           in_rd,
    input  logic                 in_rd_we,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [NUM_UNITS-1:0] unit_ready,
    output logic                 iss_valid,
    output logic [2:0]           iss_type,
    output logic [4:0]           iss_rd,
    output logic                 iss_rd_we,
    output logic [PAYLOAD_W-1:0] iss_payload,
    input  logic                 wb_valid,
    input  logic [4:0]           wb_rd,
`ifdef ISSUE_SCHED_PERF_EN
    output logic [31:0]          perf_raw_stall,
    output logic [31:0]          perf_unit_stall,
`endif
    output logic [CW-1:0]        count
);
    iss_entry_t  w_in;
    iss_entry_t  w_head;
    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic [2:0]  w_type;
    logic [31:0] w_wb_mask;
    logic [31:0] w_sbe;
    logic [31:0] w_set_mask;
    logic        w_serial;
    logic        w_hazard;
    logic [31:0] r_sb;

    assign w_in = '{utype: in_type, rj: in_rj, rj_use: in_rj_use, rk: in_rk, rk_use: in_rk_use,
                    rd: in_rd, rd_we: in_rd_we, payload: in_payload};

    assign in_ready = ~w_full;
    assign w_push   = in_valid & in_ready & ~flush;

    issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_push  (w_push),
        .i_data  (w_in),
        .i_pop   (iss_valid),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (count)
    );

    // The unused encoding 7 is steered to the ALU.
    assign w_type = (w_head.utype == 3'd7) ? TYPE_ALU : w_head.utype;

    // A same-cycle writeback releases its register before the hazard check.
    assign w_wb_mask = wb_valid ? onehot32(wb_rd) : 32'd0;
    assign w_sbe     = r_sb & ~w_wb_mask;

    assign w_serial = (w_type == TYPE_PRIV) || (w_type == TYPE_LLSC);
    assign w_hazard = (w_head.rj_use & w_sbe[w_head.rj])
                    | (w_head.rk_use & w_sbe[w_head.rk])
                    | (w_head.rd_we  & w_sbe[w_head.rd])
                    | (w_serial & (|w_sbe));

    assign iss_valid   = ~w_empty & ~w_hazard & unit_ready[w_type] & ~flush;
    assign iss_type    = w_type;
    assign iss_rd      = w_head.rd;
    assign iss_rd_we   = w_head.rd_we & (w_head.rd != 5'd0);
    assign iss_payload = w_head.payload;

    assign w_set_mask = (iss_valid & iss_rd_we) ? onehot32(iss_rd) : 32'd0;

    always_ff @(posedge clk) begin
        if (rst || flush) r_sb <= '0;
        else              r_sb <= (w_sbe | w_set_mask) & ~32'd1;
    end

`ifdef ISSUE_SCHED_PERF_EN
    logic [31:0] r_raw_stall;
    logic [31:0] r_unit_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_raw_stall  <= '0;
            r_unit_stall <= '0;
        end else begin
            if (!w_empty && w_hazard && r_raw_stall != '1)
                r_raw_stall <= r_raw_stall + 32'd1;
            if (!w_empty && !w_hazard && !unit_ready[w_type] && r_unit_stall != '1)
                r_unit_stall <= r_unit_stall + 32'd1;
        end
    end

    assign perf_raw_stall  = r_raw_stall;
    assign perf_unit_stall = r_unit_stall;
`endif
endmodule

// File: tb/tb_issue_scheduler.sv
// Scoreboard bench for issue_scheduler: expected issues queued at enqueue, compared at issue.
module tb_issue_scheduler;
    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_type;
    logic [4:0]  in_rj;
    logic        in_rj_use;
    logic [4:0]  in_rk;
    logic        in_rk_use;
    logic [4:0]  in_rd;
    logic        in_rd_we;
    logic [31:0] in_payload;
    logic [6:0]  unit_ready;
    logic        iss_valid;
    logic [2:0]  iss_type;
    logic [4:0]  iss_rd;
    logic        iss_rd_we;
    logic [31:0] iss_payload;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [2:0]  count;
`ifdef ISSUE_SCHED_PERF_EN
    logic [31:0] perf_raw_stall;
    logic [31:0] perf_unit_stall;
    logic [31:0] raw_snap;
`endif

    int          n_chk;
    int          n_err;
    logic [63:0] exp_q[$];

    issue_scheduler #(.DEPTH(4), .PAYLOAD_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_type     (in_type),
        .in_rj       (in_rj),
        .in_rj_use   (in_rj_use),
        .in_rk       (in_rk),
        .in_rk_use   (in_rk_use),
        .in_rd       (in_rd),
        .in_rd_we    (in_rd_we),
        .in_payload  (in_payload),
        .unit_ready  (unit_ready),
        .iss_valid   (iss_valid),
        .iss_type    (iss_type),
        .iss_rd      (iss_rd),
        .iss_rd_we   (iss_rd_we),
        .iss_payload (iss_payload),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
`ifdef ISSUE_SCHED_PERF_EN
        .perf_raw_stall  (perf_raw_stall),
        .perf_unit_stall (perf_unit_stall),
`endif
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_of(input logic [2:0] t, input logic [4:0] rd,
                                           input logic we, input logic [31:0] pl);
        logic [2:0] te;
        te = (t == 3'd7) ? 3'd0 : t;
        return {23'd0, te, rd, (we && rd != 5'd0), pl};
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Drive one decoded instruction; it is expected to issue only if accepted.
    task automatic enq(input logic [2:0] t, input logic [4:0] rj, input logic rju,
                       input logic [4:0] rk, input logic rku, input logic [4:0] rd,
                       input logic we, input logic [31:0] pl);
        in_valid = 1'b1; in_type = t; in_rj = rj; in_rj_use = rju;
        in_rk = rk; in_rk_use = rku; in_rd = rd; in_rd_we = we; in_payload = pl;
        if (in_ready && !flush) exp_q.push_back(exp_of(t, rd, we, pl));
    endtask

    always @(negedge clk) begin
        if (!rst && iss_valid) begin
            if (exp_q.size() == 0) chk("unexpected_issue", 64'd1, 64'd0);
            else chk("issue_fields", {23'd0, iss_type, iss_rd, iss_rd_we, iss_payload}, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int p;
        n_chk = 0; n_err = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_type = '0; in_rj = '0; in_rj_use = 1'b0;
        in_rk = '0; in_rk_use = 1'b0; in_rd = '0; in_rd_we = 1'b0; in_payload = '0;
        unit_ready = '0; wb_valid = 1'b0; wb_rd = '0;

        // reset
        nxt(); nxt();
        #3;
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_iss_valid", iss_valid, 0);
        nxt();
        rst = 1'b0;

        // single ADD: exactly one cycle enqueue-to-issue
        unit_ready = 7'h7F;
        enq(3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 32'h100);
        #3 chk("t2_same_cycle", iss_valid, 0);
        nxt(); in_valid = 1'b0;
        #3 chk("t2_latency", iss_valid, 1);
        nxt();
        #3 chk("t2_drained", count, 0);

        // RAW on r5 stalls until the bypassed writeback
        enq(3'd0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 32'h200);
        #3 chk("t3_empty", iss_valid, 0);
`ifdef ISSUE_SCHED_PERF_EN
        raw_snap = perf_raw_stall;
`endif
        nxt(); in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #3 chk("t3_raw_stall", iss_valid, 0);
            nxt();
        end
        wb_valid = 1'b1; wb_rd = 5'd5;
        #3 chk("t3_wb_bypass", iss_valid, 1);
        nxt(); wb_valid = 1'b0;
`ifdef ISSUE_SCHED_PERF_EN
        #3 chk("perf_raw_delta", perf_raw_stall - raw_snap, 4);
        chk("perf_unit_zero", perf_unit_stall, 0);
`endif
        // independent op issues immediately
        enq(3'd0, 5'd8, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 32'h300);
        nxt(); in_valid = 1'b0;
        #3 chk("t3_indep", iss_valid, 1);
        nxt();
        // WAW on r6 waits for its writeback, then re-marks r6 busy
        enq(3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 32'h310);
        nxt(); in_valid = 1'b0;
        #3 chk("t3_waw_stall", iss_valid, 0);
        nxt();
        wb_valid = 1'b1; wb_rd = 5'd6;
        #3 chk("t3_waw_release", iss_valid, 1);
        nxt(); wb_valid = 1'b0;
        // r0 never hazards and never gets marked
        enq(3'd0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 32'h320);
        nxt(); in_valid = 1'b0;
        #3 chk("t3_r0", iss_valid, 1);
        nxt();
        wb_valid = 1'b1; wb_rd = 5'd6;
        nxt(); wb_rd = 5'd10;
        nxt(); wb_valid = 1'b0;

        // fill with units blocked, then stream through pointer wrap
        unit_ready = 7'h00;
        for (int i = 0; i < 4; i++) begin
            enq(3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h400 + i);
            nxt();
        end
        in_valid = 1'b0;
        #3 chk("t4_full_count", count, 4);
        chk("t4_full_ready", in_ready, 0);
        chk("t4_blocked", iss_valid, 0);
        unit_ready = 7'h01;
        p = 32'h410;
        for (int i = 0; i < 8; i++) begin
            enq((i % 2 == 0) ? 3'd7 : 3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, p);
            if (in_ready) p++;
            #3 chk("t4_stream_count", count, (i == 0) ? 4 : 3);
            chk("t4_stream_iss", iss_valid, 1);
            nxt();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3 chk("t4_drain_iss", iss_valid, 1);
            nxt();
        end
        #3 chk("t4_drain_count", count, 0);

        // priv waits for all in-flight writes
        unit_ready = 7'h7F;
        enq(3'd4, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 32'h500);
        nxt();
        enq(3'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h510);
        #3 chk("t5_mul_iss", iss_valid, 1);
        nxt(); in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3 chk("t5_priv_wait", iss_valid, 0);
            nxt();
        end
        wb_valid = 1'b1; wb_rd = 5'd3;
        #3 chk("t5_priv_go", iss_valid, 1);
        nxt(); wb_valid = 1'b0;
        #3 chk("t5_count", count, 0);

        // flush kills queue and scoreboard, ignoring same-cycle inputs
        enq(3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 32'h600);
        nxt(); in_valid = 1'b0;
        #3 chk("t6_set_r7", iss_valid, 1);
        nxt();
        unit_ready = 7'h00;
        for (int i = 0; i < 3; i++) begin
            enq(3'd0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h610 + i);
            nxt();
        end
        in_valid = 1'b0;
        #3 chk("t6_pre_count", count, 3);
        nxt();
        flush = 1'b1; unit_ready = 7'h7F; wb_valid = 1'b1; wb_rd = 5'd9;
        enq(3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h6FF);
        #3 chk("t6_flush_iss", iss_valid, 0);
        exp_q.delete();
        nxt();
        flush = 1'b0; in_valid = 1'b0; wb_valid = 1'b0;
        #3 chk("t6_post_count", count, 0);
        chk("t6_post_iss", iss_valid, 0);
        chk("t6_post_ready", in_ready, 1);
        nxt();
        enq(3'd0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h620);
        nxt(); in_valid = 1'b0;
        #3 chk("t6_sb_cleared", iss_valid, 1);
        nxt(); nxt();

        chk("expected_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
